// File: rtl/cpu_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_ctrl -- central pipeline controller for the 5-stage core.
//
// Decides, every cycle, whether the PC / IF_ID / ID_EX stage registers hold,
// load a bubble (flush) or whether the PC is redirected to a taken jump target.
// It also parks the core in a halted state after an illegal instruction or a
// data-memory access that never completes, and keeps cycle/stall counters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_error_i          ID stage cannot decode its instruction
//   id_raddr1_i/2_i     ID stage source register addresses
//   ex_is_load_i        EX stage holds a memory-read instruction
//   ex_gprs_waddr_i     EX stage destination register
//   ex_jump_i           EX stage holds a taken jump/branch
//   ex_jump_addr_i      jump target
//   mem_req_i           EX instruction accesses data memory this cycle
//   mem_ready_i         data memory completes the access this cycle
//   pc_stall_o          hold PC
//   if_id_stall_o       hold IF_ID
//   if_id_flush_o       load NOP into IF_ID
//   id_ex_stall_o       hold ID_EX
//   id_ex_flush_o       load NOP into ID_EX
//   pc_we_o/pc_wdata_o  redirect PC to pc_wdata_o
//   halted_o            core halted (state == HALT)
//   halt_cause_o        0 none, 1 illegal instruction, 2 memory timeout
//   cycle_cnt_o         non-halted cycles since reset (wraps)
//   stall_cnt_o         non-halted cycles with pc_stall_o=1 (wraps)
//
// Memory handshake: mem_req_i acts as "valid" for the EX-stage access and
// mem_ready_i as its "ready"; the access completes only in a cycle where both
// are high. While req is high and ready is low the whole front of the pipe is
// frozen so the EX instruction stays put until ready arrives.
// -----------------------------------------------------------------------------
module cpu_ctrl #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_error_i,
  input  logic [REG_W-1:0]  id_raddr1_i,
  input  logic [REG_W-1:0]  id_raddr2_i,
  input  logic              ex_is_load_i,
  input  logic [REG_W-1:0]  ex_gprs_waddr_i,
  input  logic              ex_jump_i,
  input  logic [DATA_W-1:0] ex_jump_addr_i,
  input  logic              mem_req_i,
  input  logic              mem_ready_i,
  output logic              pc_stall_o,
  output logic              if_id_stall_o,
  output logic              if_id_flush_o,
  output logic              id_ex_stall_o,
  output logic              id_ex_flush_o,
  output logic              pc_we_o,
  output logic [DATA_W-1:0] pc_wdata_o,
  output logic              halted_o,
  output logic [1:0]        halt_cause_o,
  output logic [31:0]       cycle_cnt_o,
  output logic [31:0]       stall_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_MEMTO   = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       stall_q, stall_d;

  logic load_use;
  logic eval_run;

  // A load into x0 produces nothing to forward, so it never creates a hazard.
  assign load_use = ex_is_load_i && (ex_gprs_waddr_i != '0) &&
                    ((ex_gprs_waddr_i == id_raddr1_i) ||
                     (ex_gprs_waddr_i == id_raddr2_i));

  // ---------------------------------------------------------------------------
  // Next state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    cause_d       = cause_q;
    eval_run      = 1'b0;
    pc_stall_o    = 1'b0;
    if_id_stall_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_stall_o = 1'b0;
    id_ex_flush_o = 1'b0;
    pc_we_o       = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_req_i && !mem_ready_i) begin
          // Freeze everything; a jump seen now is re-evaluated once the
          // held EX instruction is released.
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_stall_o = 1'b1;
          state_d       = ST_MEMWAIT;
          wait_d        = WAIT_W'(1);
        end else begin
          eval_run = 1'b1;
        end
      end

      ST_MEMWAIT: begin
        if (!mem_ready_i) begin
          if (wait_q == TIMEOUT_CNT) begin
            // Give up: squash the stuck instruction and park the core.
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
            state_d       = ST_HALT;
            cause_d       = CAUSE_MEMTO;
          end else begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_stall_o = 1'b1;
            wait_d        = wait_q + 1'b1;
          end
        end else begin
          eval_run = 1'b1;
          state_d  = ST_RUN;
        end
      end

      ST_HALT: begin
        pc_stall_o    = 1'b1;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Rules shared by RUN and the completing MEMWAIT cycle.
    if (eval_run) begin
      wait_d = '0;
      if (ex_jump_i) begin
        // Anything younger than the jump is on the wrong path, including a
        // decode error in ID.
        pc_we_o       = 1'b1;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (id_error_i) begin
        pc_stall_o    = 1'b1;
        if_id_stall_o = 1'b1;
        id_ex_flush_o = 1'b1;
        state_d       = ST_HALT;
        cause_d       = CAUSE_ILLEGAL;
      end else if (load_use) begin
        // One bubble: the dependent instruction waits a cycle in ID.
        pc_stall_o    = 1'b1;
        if_id_stall_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end
    end

    if (rst) begin
      pc_stall_o    = 1'b0;
      if_id_stall_o = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_stall_o = 1'b0;
      id_ex_flush_o = 1'b1;
      pc_we_o       = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters: frozen while halted, free-running modulo 2^32.
  // ---------------------------------------------------------------------------
  always_comb begin
    cycle_d = cycle_q;
    stall_d = stall_q;
    if (state_q != ST_HALT) begin
      cycle_d = cycle_q + 32'd1;
      if (pc_stall_o) begin
        stall_d = stall_q + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      cycle_q <= cycle_d;
      stall_q <= stall_d;
    end
  end

  assign pc_wdata_o   = ex_jump_addr_i;
  assign halted_o     = (state_q == ST_HALT);
  assign halt_cause_o = cause_q;
  assign cycle_cnt_o  = cycle_q;
  assign stall_cnt_o  = stall_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
module tb_cpu_ctrl;

  localparam int DATA_W      = 32;
  localparam int REG_W       = 5;
  localparam int MEM_TIMEOUT = 4;

  // Control vector: {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
  //                  id_ex_flush, pc_we, halted}
  localparam logic [6:0] V_IDLE   = 7'b0000000;
  localparam logic [6:0] V_BUBBLE = 7'b1100100;
  localparam logic [6:0] V_MSTALL = 7'b1101000;
  localparam logic [6:0] V_JUMP   = 7'b0010110;
  localparam logic [6:0] V_HALT   = 7'b1010101;
  localparam logic [6:0] V_RST    = 7'b0010100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              id_error_i;
  logic [REG_W-1:0]  id_raddr1_i, id_raddr2_i;
  logic              ex_is_load_i;
  logic [REG_W-1:0]  ex_gprs_waddr_i;
  logic              ex_jump_i;
  logic [DATA_W-1:0] ex_jump_addr_i;
  logic              mem_req_i, mem_ready_i;
  logic              pc_stall_o, if_id_stall_o, if_id_flush_o;
  logic              id_ex_stall_o, id_ex_flush_o, pc_we_o;
  logic [DATA_W-1:0] pc_wdata_o;
  logic              halted_o;
  logic [1:0]        halt_cause_o;
  logic [31:0]       cycle_cnt_o, stall_cnt_o;

  cpu_ctrl #(
    .DATA_W(DATA_W), .REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .id_error_i(id_error_i),
    .id_raddr1_i(id_raddr1_i), .id_raddr2_i(id_raddr2_i),
    .ex_is_load_i(ex_is_load_i), .ex_gprs_waddr_i(ex_gprs_waddr_i),
    .ex_jump_i(ex_jump_i), .ex_jump_addr_i(ex_jump_addr_i),
    .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_stall_o(id_ex_stall_o),
    .id_ex_flush_o(id_ex_flush_o), .pc_we_o(pc_we_o),
    .pc_wdata_o(pc_wdata_o), .halted_o(halted_o),
    .halt_cause_o(halt_cause_o),
    .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  // ---------------- scoreboard state ----------------
  logic [6:0]  exp_q[$];
  logic [6:0]  got, exp_v;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_cyc, m_stall;

  function automatic logic [6:0] ctrl_vec();
    return {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
            id_ex_flush_o, pc_we_o, halted_o};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    id_error_i      = 1'b0;
    id_raddr1_i     = '0;
    id_raddr2_i     = '0;
    ex_is_load_i    = 1'b0;
    ex_gprs_waddr_i = '0;
    ex_jump_i       = 1'b0;
    ex_jump_addr_i  = '0;
    mem_req_i       = 1'b0;
    mem_ready_i     = 1'b0;
  endtask

  // Advance one clock; the counter model follows the expected vector of the
  // cycle just finished (halted cycles are not counted).
  task automatic tick(input logic [6:0] e);
    if (!e[0]) begin
      m_cyc = m_cyc + 32'd1;
      if (e[6]) m_stall = m_stall + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    exp_q.push_back(V_RST);
    @(negedge clk);
    got = ctrl_vec();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", got, exp_v);
    end
    checks++;
    if ({cycle_cnt_o, stall_cnt_o, halt_cause_o} !== {32'd0, 32'd0, 2'd0}) begin
      failures++;
      $display("FAIL reset_regs cyc=%0d stall=%0d cause=%0d exp 0/0/0",
               cycle_cnt_o, stall_cnt_o, halt_cause_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cyc = 0;
    m_stall = 0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(V_IDLE);
      @(negedge clk);
      got = ctrl_vec();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL idle_ctrl cyc%0d got=%b exp=%b", i, got, exp_v);
      end
      tick(exp_v);
    end
    checks++;
    if (cycle_cnt_o !== 32'd10 || stall_cnt_o !== 32'd0) begin
      failures++;
      $display("FAIL idle_counts cyc=%0d stall=%0d exp 10/0", cycle_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_load_use();
    logic hz;
    // Directed: load x5, consumer on rs2.
    ex_is_load_i = 1'b1; ex_gprs_waddr_i = 5'd5; id_raddr2_i = 5'd5;
    exp_q.push_back(V_BUBBLE);
    @(negedge clk);
    got = ctrl_vec();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL load_use_rs2 got=%b exp=%b", got, exp_v);
    end
    tick(exp_v);
    checks++;
    if (stall_cnt_o !== m_stall || m_stall !== 32'd1) begin
      failures++;
      $display("FAIL load_use_stall_cnt got=%0d exp=1", stall_cnt_o);
    end
    // Load into x0 never stalls.
    ex_gprs_waddr_i = 5'd0; id_raddr1_i = 5'd0; id_raddr2_i = 5'd0;
    exp_q.push_back(V_IDLE);
    @(negedge clk);
    got = ctrl_vec();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL load_x0 got=%b exp=%b", got, exp_v);
    end
    tick(exp_v);
    // Randomised operand mixes.
    for (int i = 0; i < 24; i++) begin
      ex_is_load_i    = 1'($urandom_range(0, 1));
      ex_gprs_waddr_i = REG_W'($urandom_range(0, 3));
      id_raddr1_i     = REG_W'($urandom_range(0, 3));
      id_raddr2_i     = REG_W'($urandom_range(0, 3));
      hz = ex_is_load_i && (ex_gprs_waddr_i != 0) &&
           (ex_gprs_waddr_i == id_raddr1_i || ex_gprs_waddr_i == id_raddr2_i);
      exp_q.push_back(hz ? V_BUBBLE : V_IDLE);
      @(negedge clk);
      got = ctrl_vec();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL load_use_rand ld=%0d wa=%0d r1=%0d r2=%0d got=%b exp=%b",
                 ex_is_load_i, ex_gprs_waddr_i, id_raddr1_i, id_raddr2_i, got, exp_v);
      end
      tick(exp_v);
    end
    clear_inputs();
    checks++;
    if (cycle_cnt_o !== m_cyc || stall_cnt_o !== m_stall) begin
      failures++;
      $display("FAIL load_use_counts cyc=%0d stall=%0d exp %0d/%0d",
               cycle_cnt_o, stall_cnt_o, m_cyc, m_stall);
    end
  endtask

  task automatic test_jump_error();
    ex_jump_i = 1'b1; ex_jump_addr_i = 32'h0000_0080; id_error_i = 1'b1;
    exp_q.push_back(V_JUMP);
    @(negedge clk);
    got = ctrl_vec();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL jump_err_ctrl got=%b exp=%b", got, exp_v);
    end
    checks++;
    if (pc_wdata_o !== 32'h0000_0080) begin
      failures++;
      $display("FAIL jump_target got=%h exp=00000080", pc_wdata_o);
    end
    tick(exp_v);
    clear_inputs();
    exp_q.push_back(V_IDLE);
    @(negedge clk);
    got = ctrl_vec();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || halt_cause_o !== 2'd0) begin
      failures++;
      $display("FAIL jump_err_stays_run got=%b cause=%0d exp=%b cause=0", got, halt_cause_o, exp_v);
    end
    tick(exp_v);
  endtask

  task automatic test_memwait();
    mem_req_i = 1'b1; mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(V_MSTALL);
      @(negedge clk);
      got = ctrl_vec();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL memwait_stall cyc%0d got=%b exp=%b", i, got, exp_v);
      end
      tick(exp_v);
    end
    mem_ready_i = 1'b1; ex_jump_i = 1'b1; ex_jump_addr_i = 32'h0000_0100;
    exp_q.push_back(V_JUMP);
    @(negedge clk);
    got = ctrl_vec();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || pc_wdata_o !== 32'h0000_0100) begin
      failures++;
      $display("FAIL memwait_release got=%b pc=%h exp=%b pc=00000100", got, pc_wdata_o, exp_v);
    end
    tick(exp_v);
    clear_inputs();
    exp_q.push_back(V_IDLE);
    @(negedge clk);
    got = ctrl_vec();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL memwait_back_to_run got=%b exp=%b", got, exp_v);
    end
    tick(exp_v);
    checks++;
    if (cycle_cnt_o !== m_cyc || stall_cnt_o !== m_stall) begin
      failures++;
      $display("FAIL memwait_counts cyc=%0d stall=%0d exp %0d/%0d",
               cycle_cnt_o, stall_cnt_o, m_cyc, m_stall);
    end
  endtask

  task automatic test_timeout();
    mem_req_i = 1'b1; mem_ready_i = 1'b0;
    // RUN entry cycle plus MEMWAIT with wait counter 1..MEM_TIMEOUT-1 stall;
    // wait counter == MEM_TIMEOUT squashes and halts.
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
      exp_q.push_back((i == MEM_TIMEOUT) ? V_BUBBLE : V_MSTALL);
      @(negedge clk);
      got = ctrl_vec();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL timeout_seq cyc%0d got=%b exp=%b", i, got, exp_v);
      end
      tick(exp_v);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(V_HALT);
      @(negedge clk);
      got = ctrl_vec();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v || halt_cause_o !== 2'd2) begin
        failures++;
        $display("FAIL timeout_halt cyc%0d got=%b cause=%0d exp=%b cause=2", i, got, halt_cause_o, exp_v);
      end
      tick(exp_v);
    end
    checks++;
    if (cycle_cnt_o !== m_cyc || stall_cnt_o !== m_stall) begin
      failures++;
      $display("FAIL timeout_frozen cyc=%0d stall=%0d exp %0d/%0d",
               cycle_cnt_o, stall_cnt_o, m_cyc, m_stall);
    end
    test_reset();
    checks++;
    if (halted_o !== 1'b0 || halt_cause_o !== 2'd0 || cycle_cnt_o !== 32'd0) begin
      failures++;
      $display("FAIL timeout_rst_clear halted=%0d cause=%0d cyc=%0d exp 0/0/0",
               halted_o, halt_cause_o, cycle_cnt_o);
    end
  endtask

  task automatic test_illegal();
    id_error_i = 1'b1;
    exp_q.push_back(V_BUBBLE);
    @(negedge clk);
    got = ctrl_vec();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL illegal_entry got=%b exp=%b", got, exp_v);
    end
    tick(exp_v);
    id_error_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ex_jump_i      = 1'b1;
      ex_jump_addr_i = DATA_W'($urandom);
      mem_req_i      = 1'($urandom_range(0, 1));
      mem_ready_i    = 1'($urandom_range(0, 1));
      id_error_i     = 1'($urandom_range(0, 1));
      exp_q.push_back(V_HALT);
      @(negedge clk);
      got = ctrl_vec();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v || halt_cause_o !== 2'd1) begin
        failures++;
        $display("FAIL illegal_halt cyc%0d got=%b cause=%0d exp=%b cause=1", i, got, halt_cause_o, exp_v);
      end
      tick(exp_v);
    end
    clear_inputs();
    checks++;
    if (cycle_cnt_o !== m_cyc || stall_cnt_o !== m_stall) begin
      failures++;
      $display("FAIL illegal_counts cyc=%0d stall=%0d exp %0d/%0d",
               cycle_cnt_o, stall_cnt_o, m_cyc, m_stall);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- sequence + report ----------------
  initial begin
    m_cyc = 0;
    m_stall = 0;
    test_reset();
    test_idle();
    test_load_use();
    test_jump_error();
    test_memwait();
    test_timeout();
    test_illegal();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
